// File: rtl/fsqrt_issue_ctrl_pkg.sv
// fsqrt_issue_ctrl_pkg: shared FPU constants: controller state encoding, rounding modes, FP register width, register-match helper
package fsqrt_issue_ctrl_pkg;
  localparam int FP_REG_W = 5;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_WB = 2'd3;
  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RDN = 2'd2;
  localparam logic [1:0] RM_RUP = 2'd3;
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_LAUNCH = ST_LAUNCH,
    S_WAIT = ST_WAIT,
    S_WB = ST_WB
  } state_t;
  function automatic logic reg_match(input logic use_r, input logic [FP_REG_W-1:0] a, input logic [FP_REG_W-1:0] b);
    return use_r & (a == b);
  endfunction
endpackage

// File: rtl/fsqrt_hazard_cmp.sv
// fsqrt_hazard_cmp: combinational stall comparator (structural: long-latency op in ID while controller or unit busy; RAW: ID source matches pending destination)
module fsqrt_hazard_cmp
  import fsqrt_issue_ctrl_pkg::*;
(
  input  logic                i_ctrl_busy,
  input  logic                i_unit_busy,
  input  logic                i_id_op,
  input  logic                i_pend_v,
  input  logic [FP_REG_W-1:0] i_pend_fd,
  input  logic [FP_REG_W-1:0] i_id_fs,
  input  logic [FP_REG_W-1:0] i_id_ft,
  input  logic                i_id_use_fs,
  input  logic                i_id_use_ft,
  output logic                o_stall
);
  logic w_struct, w_raw;
  assign w_struct = i_id_op & (i_ctrl_busy | i_unit_busy);
  assign w_raw = i_pend_v & (reg_match(i_id_use_fs, i_id_fs, i_pend_fd) | reg_match(i_id_use_ft, i_id_ft, i_pend_fd));
  assign o_stall = w_struct | w_raw;
endmodule

// File: rtl/fsqrt_issue_ctrl.sv
// fsqrt_issue_ctrl: sqrt issue/write-back FSM (i_id_* capture, o_u_* launch to unit, i_u_busy/i_u_s completion, o_wb_* write-back, o_stall, sticky o_timeout)
module fsqrt_issue_ctrl
  import fsqrt_issue_ctrl_pkg::*;
#(
  parameter int MAX_CYCLES = 31
) (
  input  logic                i_clk,
  input  logic                i_clr,
  input  logic                i_ena,
  input  logic                i_id_fsqrt,
  input  logic [31:0]         i_id_d,
  input  logic [1:0]          i_id_rm,
  input  logic [FP_REG_W-1:0] i_id_fd,
  input  logic [FP_REG_W-1:0] i_id_fs,
  input  logic [FP_REG_W-1:0] i_id_ft,
  input  logic                i_id_use_fs,
  input  logic                i_id_use_ft,
  input  logic                i_flush,
  output logic                o_u_start,
  output logic [31:0]         o_u_d,
  output logic [1:0]          o_u_rm,
  input  logic                i_u_busy,
  input  logic [31:0]         i_u_s,
  output logic                o_stall,
  output logic                o_wb_valid,
  output logic [FP_REG_W-1:0] o_wb_fd,
  output logic [31:0]         o_wb_s,
  output logic                o_timeout
);
  localparam logic [4:0] MAX_C = 5'(MAX_CYCLES);
  state_t r_state;
  logic r_start, r_busy, r_pend_v, r_wb_valid, r_timeout;
  logic [31:0] r_u_d, r_wb_s;
  logic [1:0] r_u_rm;
  logic [FP_REG_W-1:0] r_pend_fd, r_wb_fd;
  logic [4:0] r_cnt, w_cnt_nxt;
  logic w_fall, w_capture;
  assign w_cnt_nxt = r_cnt + 5'd1;
  assign w_fall = r_busy & ~i_u_busy;
  assign w_capture = i_ena & i_id_fsqrt & ~i_flush & ~i_u_busy;
  fsqrt_hazard_cmp u_hazard (
    .i_ctrl_busy(r_state != S_IDLE),
    .i_unit_busy(i_u_busy),
    .i_id_op    (i_id_fsqrt),
    .i_pend_v   (r_pend_v),
    .i_pend_fd  (r_pend_fd),
    .i_id_fs    (i_id_fs),
    .i_id_ft    (i_id_ft),
    .i_id_use_fs(i_id_use_fs),
    .i_id_use_ft(i_id_use_ft),
    .o_stall    (o_stall)
  );
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      r_busy <= 1'b0;
      r_pend_v <= 1'b0;
      r_wb_valid <= 1'b0;
      r_timeout <= 1'b0;
      r_u_d <= '0;
      r_u_rm <= RM_RNE;
      r_pend_fd <= '0;
      r_wb_fd <= '0;
      r_wb_s <= '0;
      r_cnt <= '0;
    end else begin
      r_busy <= i_u_busy;
      r_start <= 1'b0;
      r_wb_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_capture) begin
          r_u_d <= i_id_d;
          r_u_rm <= i_id_rm;
          r_pend_fd <= i_id_fd;
          r_pend_v <= 1'b1;
          r_start <= 1'b1;
          r_state <= S_LAUNCH;
        end
        S_LAUNCH: begin
          r_cnt <= '0;
          r_pend_v <= ~i_flush;
          r_state <= i_flush ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= w_cnt_nxt;
          if (i_flush) begin
            r_pend_v <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_fall) begin
            r_wb_s <= i_u_s;
            r_wb_fd <= r_pend_fd;
            r_wb_valid <= 1'b1;
            r_state <= S_WB;
          end else if (w_cnt_nxt == MAX_C) begin
            r_timeout <= 1'b1;
            r_pend_v <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_pend_v <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
  assign o_u_start = r_start;
  assign o_u_d = r_u_d;
  assign o_u_rm = r_u_rm;
  assign o_wb_valid = r_wb_valid;
  assign o_wb_fd = r_wb_fd;
  assign o_wb_s = r_wb_s;
  assign o_timeout = r_timeout;
endmodule

// File: doc/fsqrt_issue_ctrl.md
# fsqrt_issue_ctrl

Issue/write-back controller placed directly upstream of the iterative Newton-Raphson square-root unit in the pipelined FPU. It captures an fsqrt instruction from the ID stage, launches the sqrt unit with latched operands, and stalls dependent instructions. It delivers the finished result to the FP register-file write port with a one-cycle valid pulse. Flush and a watchdog timeout are supported.

## Interface
- `MAX_CYCLES`, default 31: watchdog limit in cycles from launch to result; must fit the 5-bit counter.
- `clk`  in  1  rising-edge clock.
- `clr`  in  1  synchronous active-high reset.
- `ena`  in  1  pipeline advance enable; ID inputs are sampled only when high.
- `id_fsqrt`  in  1  ID stage holds an fsqrt instruction.
- `id_d`  in  32  IEEE-754 single-precision operand.
- `id_rm`  in  2  rounding mode.
- `id_fd`  in  5  destination FP register.
- `id_fs`, `id_ft`  in  5 each  source FP registers of the instruction currently in ID.
- `id_use_fs`, `id_use_ft`  in  1 each  the corresponding source is actually read.
- `flush`  in  1  discard the in-flight sqrt (exception/redirect).
- `u_start`  out  1  one-cycle launch pulse to the sqrt unit.
- `u_d`  out  32  latched operand.
- `u_rm`  out  2  latched rounding mode.
- `u_busy`  in  1  sqrt unit iterating.
- `u_s`  in  32  sqrt result, valid in the cycle `u_busy` falls.
- `stall`  out  1  freeze IF/ID.
- `wb_valid`  out  1  one-cycle write-back strobe.
- `wb_fd`  out  5  write-back register.
- `wb_s`  out  32  write-back data.
- `timeout`  out  1  sticky watchdog flag; cleared only by `clr`.

## Operation
- States: IDLE, LAUNCH, WAIT, WB.
- **IDLE**
  - On `ena & id_fsqrt & ~flush`: latch `id_d`/`id_rm`/`id_fd` into `u_d`/`u_rm`/`pend_fd`, set `pend_v`, go to LAUNCH.
- **LAUNCH**
  - `u_start=1` for exactly this cycle; clear the cycle counter; go to WAIT.
- **WAIT**
  - Counter increments each cycle.
  - `u_busy` falling edge (registered `u_busy` was 1, current is 0): capture `u_s` into `wb_s`, go to WB.
  - If the counter reaches `MAX_CYCLES` before that: set `timeout`, clear `pend_v`, go to IDLE with no write-back.
- **WB**
  - `wb_valid=1`, `wb_fd=pend_fd`; clear `pend_v`; go to IDLE.
- **stall** is asserted when any of:
  - state ≠ IDLE and `id_fsqrt`: structural hazard; a second sqrt waits.
  - `pend_v` and (`id_use_fs & id_fs==pend_fd` or `id_use_ft & id_ft==pend_fd`): RAW hazard.
- **flush**
  - Any state except IDLE: return to IDLE next cycle, clear `pend_v`, suppress `wb_valid`.
  - The sqrt unit is not aborted. Its next `u_busy` falling edge is ignored, because a new launch is blocked until `u_busy` is low.
  - In IDLE, flush has priority over capture.
- **Re-issue**: leaving IDLE also requires `~u_busy`. A sqrt in ID while a flushed op drains stalls.
- **Back-to-back**: an instruction captured in the same cycle WB fires is not allowed; WB always returns to IDLE first.

## Timing
- Reset values: state IDLE, `u_start=0`, `u_d=0`, `u_rm=0`, `stall=0`, `wb_valid=0`, `wb_fd=0`, `wb_s=0`, `timeout=0`, `pend_v=0`, counter 0.
- Capture at edge N → `u_start` high in cycle N+1.
- `u_busy` falls in cycle M → `wb_valid` high in cycle M+1.
- Launch-to-write-back latency = unit latency + 2.
- `stall` is combinational from state, `pend_v` and the ID fields; no cycle of delay.
- `wb_valid` is registered and never high two cycles in a row.

## Structure
- Shared FPU package: state encoding (2-bit localparams), rounding-mode constants, `FP_REG_W=5`.
- One natural sub-module: `fsqrt_hazard_cmp`, the combinational RAW/structural stall comparator, reusable by a future fdiv controller.
- Counter and FSM stay in the top module.

## Test plan
- **Basic**: `id_d=0x41100000` (9.0), rm=0, fd=3; unit model busy 20 cycles → one `u_start` pulse; `wb_valid` with `wb_fd=3`, `wb_s=0x40400000` exactly 1 cycle after busy falls.
- **Denormal**: `id_d=0x00003200` → `u_d=0x00003200` passed unchanged; write-back of the model's result.
- **RAW hazard**: sqrt to fd=5, then an add with `id_fs=5`, `id_use_fs=1` → `stall` high every cycle until the WB cycle, low the cycle after; `id_fs=6` → no stall.
- **Flush mid-WAIT**: flush at cycle 8 of WAIT → no `wb_valid`; a new sqrt in ID stalls until the model drops busy, then launches normally.
- **Watchdog**: model holds busy forever, `MAX_CYCLES=31` → `timeout` set 31 cycles after launch; no write-back; `timeout` stays set until `clr`.
- **Reset mid-operation**: `clr` during WAIT → all outputs at reset values next cycle; a later busy fall produces no `wb_valid`.
